player_cannon: RTL and testbench
================================

Name: player_cannon

Overview:
- Player-side stage that sits directly upstream of `game`. It owns the player cannon and a single player shot.
- Advances both once per frame, on the `frame_tick` pulse derived from the end of the active display area.
- Detects shot/invader hits against the invader grid exported by `game` and issues one-cycle kill strobes that `game` uses to set `killed_invaders`.
- Also renders the cannon and shot pixels for the same logical 320x200 query coordinates that `game` answers, so the two pixel outputs are ORed.

Parameters:
- CANNON_Y, 184, logical row of the cannon sprite top (sprite is 13 wide x 8 tall).
- CANNON_X_MIN, 4, leftmost cannon x.
- CANNON_X_MAX, 300, rightmost cannon x (316-16).
- CANNON_X_RESET, 153, cannon x after reset.
- SHOT_SPEED, 4, rows the shot climbs per frame.
- SHOT_TOP, 4, shot is retired when its next y would be below this row.
- GRID_COLS, 11, invader columns; the grid is 5 rows of 16x16 cells.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per frame
- btn_left  in  1  raw asynchronous button
- btn_right  in  1  raw asynchronous button
- btn_fire  in  1  raw asynchronous button
- game_over  in  1  level; freezes the block
- first_invader_x  in  9  grid origin x from `game`
- first_invader_y  in  8  grid origin y from `game`
- killed_invaders  in  55  kill mask from `game`
- query_x  in  9  logical pixel x being drawn
- query_y  in  8  logical pixel y being drawn
- pixel  out  1  cannon/shot pixel at the query coordinates (combinational)
- kill_valid  out  1  one-cycle hit strobe
- kill_index  out  6  invader index (col + row*11); valid with kill_valid
- cannon_x  out  9  current cannon x
- shot_active  out  1  shot in flight
- shot_x  out  9  shot column
- shot_y  out  8  shot tip row

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - cannon_x=CANNON_X_RESET, shot_active=0, shot_x=0, shot_y=0.
  - kill_valid=0, kill_index=0, state=IDLE, all button history 0.
- Buttons:
  - Each button goes through a 2-flop synchroniser.
  - The synchronised level is sampled on frame_tick into cur/prev registers.
  - A button counts as held when both cur and prev samples are 1 (two-frame debounce).
  - fire_edge is asserted when fire is held this frame and was not held on the previous frame.
- State machine:
  - IDLE: on frame_tick with game_over=0, go to MOVE. frame_tick in any other state is ignored.
  - MOVE (1 cycle), cannon:
    - Left held and right not held: cannon_x-1, saturating at CANNON_X_MIN.
    - Right held and left not held: cannon_x+1, saturating at CANNON_X_MAX.
    - Both held or neither held: no change.
  - MOVE, shot:
    - If shot_active and shot_y < SHOT_TOP+SHOT_SPEED: shot_active<=0.
    - Else if shot_active: shot_y<=shot_y-SHOT_SPEED.
    - Else if fire_edge: shot_active<=1, shot_x<=cannon_x+6 (pre-move value), shot_y<=CANNON_Y-4.
    - Then go to CHECK.
  - CHECK (1 cycle), using the registered shot tip:
    - rx = shot_x - first_invader_x and ry = shot_y - first_invader_y, both 9-bit.
    - Candidate hit requires: shot_active, shot_x >= first_invader_x, rx < 176, shot_y >= first_invader_y, ry < 80.
    - Candidate is a hit when, with col=rx>>4, row=ry>>4, sx=rx[3:0], sy=ry[3:0]:
      - sy >= 8;
      - sx < width, where width is 8 for row 0, 11 for rows 1-2 and 12 for rows 3-4;
      - killed_invaders[col+row*11] = 0.
    - On a hit: latch kill_index, clear shot_active, go to KILL. Otherwise go to IDLE.
  - KILL: kill_valid=1 for exactly this cycle, then IDLE.
  - Latency: kill_valid asserts 3 cycles after the frame_tick that moved the shot onto the target.
- game_over:
  - While high, IDLE does not leave, so nothing moves and no kills are issued.
  - Asserting it mid-sequence lets the current sequence finish, but KILL is suppressed: kill_valid stays 0 and the shot is still cleared.
- pixel (combinational) is 1 when either holds:
  - query_y in [CANNON_Y, CANNON_Y+7] and query_x in [cannon_x, cannon_x+12];
  - shot_active, query_x == shot_x and query_y in [shot_y, shot_y+3].
- Reset mid-sequence: the asynchronous return to reset values drops any pending kill_valid immediately.

Test Plan:
- Reset, 5 ticks with no buttons -> cannon_x=153, shot_active=0, kill_valid never asserted, pixel=1 at (153,184) and (165,191), pixel=0 at (166,184).
- btn_right held for 200 ticks -> cannon_x reaches 300 and stays there; release, then btn_left held for 400 ticks -> cannon_x stays at 4; both buttons held -> cannon_x unchanged.
- Fire pulse held for 2 ticks with cannon_x=153 -> shot spawns at x=159, y=180; later ticks read y=176, 172, ...; shot retires when y < 8; holding fire continuously spawns no second shot.
- Grid origin (4,20), killed_invaders=0, shot_x=4, shot_y=31 (cell 0, sy=11) -> kill_valid for 1 cycle with kill_index=0, 3 cycles after the tick; shot_active=0.
- Shot tip at rx=9, ry=12 (row 0, sx=9 >= width 8) -> no kill; at rx=25, ry=76 (col 1, row 4, sx=9 < width 12) -> kill_index=45.
- Same hit but killed_invaders[45]=1 -> no strobe and the shot continues; game_over=1 -> 10 ticks with no movement and no kill; rst_n pulsed low while in KILL -> kill_valid drops asynchronously.

Source files
------------

// File: rtl/player_cannon_if.sv
// Bundle between the player cannon stage and its surroundings: frame pulse, buttons, grid state, pixel query, kill strobe.
// The slave modport is the cannon block; the master side is the game/video logic that drives it.
interface player_cannon_if;
    logic        frame_tick;
    logic        btn_left;
    logic        btn_right;
    logic        btn_fire;
    logic        game_over;
    logic [8:0]  first_invader_x;
    logic [7:0]  first_invader_y;
    logic [54:0] killed_invaders;
    logic [8:0]  query_x;
    logic [7:0]  query_y;
    logic        pixel;
    logic        kill_valid;
    logic [5:0]  kill_index;
    logic [8:0]  cannon_x;
    logic        shot_active;
    logic [8:0]  shot_x;
    logic [7:0]  shot_y;

    modport master (
        output frame_tick, btn_left, btn_right, btn_fire, game_over,
        output first_invader_x, first_invader_y, killed_invaders, query_x, query_y,
        input  pixel, kill_valid, kill_index, cannon_x, shot_active, shot_x, shot_y
    );

    modport slave (
        input  frame_tick, btn_left, btn_right, btn_fire, game_over,
        input  first_invader_x, first_invader_y, killed_invaders, query_x, query_y,
        output pixel, kill_valid, kill_index, cannon_x, shot_active, shot_x, shot_y
    );
endinterface

// File: rtl/player_cannon.sv
// Player cannon and single shot: per-frame move, shot/invader hit test, cannon/shot pixel render.
// Latency: kill_valid 3 cycles after frame_tick; no backpressure, frame_tick is a fire-and-forget pulse.
module player_cannon #(
    parameter int CANNON_Y       = 184,
    parameter int CANNON_X_MIN   = 4,
    parameter int CANNON_X_MAX   = 300,
    parameter int CANNON_X_RESET = 153,
    parameter int SHOT_SPEED     = 4,
    parameter int SHOT_TOP       = 4,
    parameter int GRID_COLS      = 11
) (
    input  logic           clk,
    input  logic           rst_n,
    player_cannon_if.slave bus
);

    localparam logic [8:0] X_MIN       = 9'(CANNON_X_MIN);
    localparam logic [8:0] X_MAX       = 9'(CANNON_X_MAX);
    localparam logic [8:0] X_RESET     = 9'(CANNON_X_RESET);
    localparam logic [7:0] CY_TOP      = 8'(CANNON_Y);
    localparam logic [7:0] CY_BOT      = 8'(CANNON_Y + 7);
    localparam logic [7:0] SHOT_START  = 8'(CANNON_Y - 4);
    localparam logic [7:0] SHOT_STEP   = 8'(SHOT_SPEED);
    localparam logic [7:0] SHOT_RETIRE = 8'(SHOT_TOP + SHOT_SPEED);
    localparam logic [8:0] GRID_W      = 9'(GRID_COLS * 16);
    localparam logic [8:0] GRID_H      = 9'd80;
    localparam logic [5:0] COLS        = 6'(GRID_COLS);

    typedef enum logic [1:0] {IDLE, MOVE, CHECK, KILL} state_t;

    state_t      state, state_nxt;
    logic [2:0]  sync1, sync2, cur, prev;
    logic        fire_pp;
    logic [2:0]  held;
    logic        fire_edge;

    logic [8:0]  cannon_q, cannon_nxt;
    logic        shot_act_q, shot_act_nxt;
    logic [8:0]  shot_x_q, shot_x_nxt;
    logic [7:0]  shot_y_q, shot_y_nxt;
    logic [5:0]  kill_idx_q, kill_idx_nxt;

    logic [8:0]  rx, ry;
    logic [3:0]  col;
    logic [2:0]  row;
    logic [3:0]  cell_w;
    logic        cand, hit;
    logic [5:0]  hit_index;

    logic [9:0]  cannon_right;
    logic [8:0]  shot_bottom;
    logic        in_cannon, in_shot;

    // Bit order in button vectors: [0]=left, [1]=right, [2]=fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            cur     <= '0;
            prev    <= '0;
            fire_pp <= 1'b0;
        end else begin
            sync1 <= {bus.btn_fire, bus.btn_right, bus.btn_left};
            sync2 <= sync1;
            if (bus.frame_tick) begin
                cur     <= sync2;
                prev    <= cur;
                fire_pp <= prev[2];
            end
        end
    end

    assign held      = cur & prev;
    assign fire_edge = held[2] & ~(prev[2] & fire_pp);

    // Hit test against the registered shot tip; the grid is 5 rows of 16x16 cells.
    always_comb begin
        rx        = shot_x_q - bus.first_invader_x;
        ry        = {1'b0, shot_y_q} - {1'b0, bus.first_invader_y};
        cand      = shot_act_q && (shot_x_q >= bus.first_invader_x) && (rx < GRID_W) &&
                    (shot_y_q >= bus.first_invader_y) && (ry < GRID_H);
        col       = rx[7:4];
        row       = ry[6:4];
        case (row)
            3'd0:       cell_w = 4'd8;
            3'd1, 3'd2: cell_w = 4'd11;
            default:    cell_w = 4'd12;
        endcase
        hit_index = {2'b00, col} + ({3'b000, row} * COLS);
        hit       = cand && ry[3] && (rx[3:0] < cell_w) && !bus.killed_invaders[hit_index];
    end

    always_comb begin
        state_nxt    = state;
        cannon_nxt   = cannon_q;
        shot_act_nxt = shot_act_q;
        shot_x_nxt   = shot_x_q;
        shot_y_nxt   = shot_y_q;
        kill_idx_nxt = kill_idx_q;
        case (state)
            IDLE: begin
                if (bus.frame_tick && !bus.game_over) state_nxt = MOVE;
            end
            MOVE: begin
                if (held[0] && !held[1]) begin
                    cannon_nxt = (cannon_q > X_MIN) ? cannon_q - 9'd1 : X_MIN;
                end else if (held[1] && !held[0]) begin
                    cannon_nxt = (cannon_q < X_MAX) ? cannon_q + 9'd1 : X_MAX;
                end
                // Spawn uses the pre-move cannon position so the shot leaves the barrel it was fired from.
                if (shot_act_q && (shot_y_q < SHOT_RETIRE)) begin
                    shot_act_nxt = 1'b0;
                end else if (shot_act_q) begin
                    shot_y_nxt = shot_y_q - SHOT_STEP;
                end else if (fire_edge) begin
                    shot_act_nxt = 1'b1;
                    shot_x_nxt   = cannon_q + 9'd6;
                    shot_y_nxt   = SHOT_START;
                end
                state_nxt = CHECK;
            end
            CHECK: begin
                if (hit) begin
                    kill_idx_nxt = hit_index;
                    shot_act_nxt = 1'b0;
                    state_nxt    = KILL;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cannon_q   <= X_RESET;
            shot_act_q <= 1'b0;
            shot_x_q   <= '0;
            shot_y_q   <= '0;
            kill_idx_q <= '0;
        end else begin
            state      <= state_nxt;
            cannon_q   <= cannon_nxt;
            shot_act_q <= shot_act_nxt;
            shot_x_q   <= shot_x_nxt;
            shot_y_q   <= shot_y_nxt;
            kill_idx_q <= kill_idx_nxt;
        end
    end

    // Shot is drawn 1 pixel wide and 4 tall from its tip downwards.
    always_comb begin
        cannon_right = {1'b0, cannon_q} + 10'd12;
        shot_bottom  = {1'b0, shot_y_q} + 9'd3;
        in_cannon    = (bus.query_y >= CY_TOP) && (bus.query_y <= CY_BOT) &&
                       (bus.query_x >= cannon_q) && ({1'b0, bus.query_x} <= cannon_right);
        in_shot      = shot_act_q && (bus.query_x == shot_x_q) &&
                       (bus.query_y >= shot_y_q) && ({1'b0, bus.query_y} <= shot_bottom);
    end

    // Strobe is gated by game_over so a kill raced by end-of-game is dropped.
    assign bus.kill_valid  = (state == KILL) && !bus.game_over;
    assign bus.kill_index  = kill_idx_q;
    assign bus.pixel       = in_cannon | in_shot;
    assign bus.cannon_x    = cannon_q;
    assign bus.shot_active = shot_act_q;
    assign bus.shot_x      = shot_x_q;
    assign bus.shot_y      = shot_y_q;

endmodule

// File: tb/tb_player_cannon.sv
// Bench for player_cannon: directed scenarios plus randomized frames checked against a frame-level model.
module tb_player_cannon;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    player_cannon_if bus ();
    player_cannon dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int kv_count = 0;
    int kv_idx   = -1;
    int kv_cyc   = -1;
    always @(negedge clk) begin
        if (bus.kill_valid === 1'b1) begin
            kv_count++;
            kv_idx = int'(bus.kill_index);
            kv_cyc = cyc;
        end
    end

    // Model: cannon/shot positions as integers and the per-frame button samples as queues.
    int          m_cx = 153, m_act = 0, m_sx = 0, m_sy = 0;
    bit          ql[$], qr[$], qf[$];
    int          g_fx = 0, g_fy = 200;
    logic [54:0] g_killed = '0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit held_ago(input bit q[$], input int ago);
        int n = q.size();
        return (n >= ago + 2) && q[n - 1 - ago] && q[n - 2 - ago];
    endfunction

    task automatic set_grid(input int fx, input int fy, input logic [54:0] killed);
        g_fx = fx; g_fy = fy; g_killed = killed;
        bus.first_invader_x = 9'(fx);
        bus.first_invader_y = 8'(fy);
        bus.killed_invaders = killed;
    endtask

    task automatic model_reset();
        m_cx = 153; m_act = 0; m_sx = 0; m_sy = 0;
        ql.delete(); qr.delete(); qf.delete();
    endtask

    task automatic model_frame(input bit l, input bit r, input bit f, input bit go,
                               output bit hit, output int idx);
        bit L, R, fe;
        int old, rx, ry, col, row, w;
        ql.push_back(l); qr.push_back(r); qf.push_back(f);
        hit = 0; idx = 0;
        if (!go) begin
            L   = held_ago(ql, 0);
            R   = held_ago(qr, 0);
            fe  = held_ago(qf, 0) && !held_ago(qf, 1);
            old = m_cx;
            if (L && !R)      m_cx = (m_cx > 4)   ? m_cx - 1 : 4;
            else if (R && !L) m_cx = (m_cx < 300) ? m_cx + 1 : 300;
            if (m_act && m_sy < 8) m_act = 0;
            else if (m_act)        m_sy = m_sy - 4;
            else if (fe) begin
                m_act = 1; m_sx = old + 6; m_sy = 180;
            end
            if (m_act) begin
                rx = m_sx - g_fx;
                ry = m_sy - g_fy;
                if (rx >= 0 && rx < 176 && ry >= 0 && ry < 80) begin
                    col = rx / 16;
                    row = ry / 16;
                    w   = (row == 0) ? 8 : (row <= 2) ? 11 : 12;
                    if ((ry % 16) >= 8 && (rx % 16) < w && !g_killed[col + row * 11]) begin
                        hit = 1; idx = col + row * 11; m_act = 0;
                    end
                end
            end
        end
    endtask

    task automatic tick(input bit l, input bit r, input bit f, input bit go, input bit go_mid);
        int kv0, t0, idx, exp_kv;
        bit hit;
        bus.btn_left = l; bus.btn_right = r; bus.btn_fire = f; bus.game_over = go;
        repeat (3) @(negedge clk);
        kv0 = kv_count;
        bus.frame_tick = 1'b1;
        t0 = cyc;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        if (go_mid) bus.game_over = 1'b1;
        repeat (5) @(negedge clk);
        bus.game_over = go;
        model_frame(l, r, f, go, hit, idx);
        exp_kv = (hit && !go_mid) ? 1 : 0;
        chk("cannon_x",    int'(bus.cannon_x),    m_cx);
        chk("shot_active", int'(bus.shot_active), m_act);
        chk("shot_x",      int'(bus.shot_x),      m_sx);
        chk("shot_y",      int'(bus.shot_y),      m_sy);
        chk("kill_strobes", kv_count - kv0,       exp_kv);
        if (exp_kv == 1) begin
            chk("kill_index",   kv_idx, idx);
            chk("kill_latency", kv_cyc, t0 + 3);
        end
    endtask

    task automatic pix(input int qx, input int qy);
        int e;
        if (qx < 0) qx = 0;
        if (qy < 0) qy = 0;
        bus.query_x = 9'(qx);
        bus.query_y = 8'(qy);
        #1;
        e = ((qy >= 184 && qy <= 191 && qx >= m_cx && qx <= m_cx + 12) ||
             (m_act != 0 && qx == m_sx && qy >= m_sy && qy <= m_sy + 3)) ? 1 : 0;
        chk("pixel", int'(bus.pixel), e);
    endtask

    task automatic spawn();
        set_grid(0, 200, '0);
        tick(0, 0, 1, 0, 0);
        tick(0, 0, 1, 0, 0);
    endtask

    initial begin
        int saved, t0, nx, ny, fx, fy;
        bit l, r, f, go, gm;
        logic [63:0] rk;

        bus.frame_tick = 0; bus.btn_left = 0; bus.btn_right = 0; bus.btn_fire = 0;
        bus.game_over = 0; bus.query_x = 0; bus.query_y = 0;
        set_grid(0, 200, '0);
        repeat (2) @(negedge clk);
        chk("rst_cannon_x",    int'(bus.cannon_x),    153);
        chk("rst_shot_active", int'(bus.shot_active), 0);
        chk("rst_shot_x",      int'(bus.shot_x),      0);
        chk("rst_shot_y",      int'(bus.shot_y),      0);
        chk("rst_kill_valid",  int'(bus.kill_valid),  0);
        chk("rst_kill_index",  int'(bus.kill_index),  0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0);
        pix(153, 184); chk("pix_cannon_tl", int'(bus.pixel), 1);
        pix(165, 191); chk("pix_cannon_br", int'(bus.pixel), 1);
        pix(166, 184); chk("pix_cannon_out", int'(bus.pixel), 0);

        // Fire pulse over two frames, then watch the shot climb and retire.
        spawn();
        chk("spawn_x", int'(bus.shot_x), 159);
        chk("spawn_y", int'(bus.shot_y), 180);
        pix(159, 183);
        tick(0, 0, 0, 0, 0);
        chk("climb_y", int'(bus.shot_y), 176);
        for (int i = 0; i < 46; i++) tick(0, 0, 0, 0, 0);
        chk("retired", int'(bus.shot_active), 0);
        for (int i = 0; i < 60; i++) tick(0, 0, 1, 0, 0);
        chk("hold_fire_single_shot", int'(bus.shot_active), 0);
        tick(0, 0, 0, 0, 0);

        // Cell 0 hit, rx=0 ry=11.
        spawn();
        set_grid(m_sx, m_sy - 4 - 11, '0);
        tick(0, 0, 0, 0, 0);
        chk("hit0_index", kv_idx, 0);
        chk("hit0_shot_cleared", int'(bus.shot_active), 0);

        // rx=9 ry=12 misses the narrow row-0 sprite; rx=25 ry=76 hits index 45.
        spawn();
        set_grid(m_sx - 9, m_sy - 4 - 12, '0);
        tick(0, 0, 0, 0, 0);
        chk("narrow_miss_active", int'(bus.shot_active), 1);
        set_grid(m_sx - 25, m_sy - 4 - 76, '0);
        tick(0, 0, 0, 0, 0);
        chk("hit45_index", kv_idx, 45);

        // Already-killed invader lets the shot through.
        spawn();
        rk = '0; rk[45] = 1'b1;
        set_grid(m_sx - 25, m_sy - 4 - 76, rk[54:0]);
        tick(0, 0, 0, 0, 0);
        chk("dead_target_active", int'(bus.shot_active), 1);

        // game_over freezes everything even with a live target in line.
        set_grid(m_sx - 25, m_sy - 76, '0);
        saved = m_cx;
        for (int i = 0; i < 10; i++) tick(0, 1, 0, 1, 0);
        chk("frozen_cannon", int'(bus.cannon_x), saved);

        // game_over raised mid-sequence: shot cleared, strobe suppressed.
        set_grid(m_sx - 25, m_sy - 4 - 76, '0);
        tick(0, 1, 0, 0, 1);
        chk("gomid_shot_cleared", int'(bus.shot_active), 0);
        tick(0, 0, 0, 0, 0);

        // Reset asserted during KILL drops the strobe immediately.
        spawn();
        set_grid(m_sx, m_sy - 4 - 11, '0);
        bus.btn_fire = 0;
        repeat (3) @(negedge clk);
        bus.frame_tick = 1'b1;
        t0 = cyc;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("kv_before_rst", int'(bus.kill_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("kv_async_drop", int'(bus.kill_valid), 0);
        chk("rst_mid_cannon", int'(bus.cannon_x), 153);
        chk("rst_mid_shot", int'(bus.shot_active), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        set_grid(0, 200, '0);

        // Saturation at both ends, then both buttons held.
        for (int i = 0; i < 200; i++) tick(0, 1, 0, 0, 0);
        chk("sat_right", int'(bus.cannon_x), 300);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) tick(1, 0, 0, 0, 0);
        chk("sat_left", int'(bus.cannon_x), 4);
        for (int i = 0; i < 10; i++) tick(0, 1, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        saved = m_cx;
        for (int i = 0; i < 3; i++) tick(1, 1, 0, 0, 0);
        chk("both_held", int'(bus.cannon_x), saved);

        // Randomized frames with the grid often aimed at the shot's next position.
        for (int i = 0; i < 300; i++) begin
            l  = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            f  = 1'($urandom_range(0, 1));
            go = ($urandom_range(0, 19) == 0);
            gm = ($urandom_range(0, 9) == 0);
            if (m_act != 0) begin nx = m_sx; ny = m_sy - 4; end
            else begin nx = m_cx + 6; ny = 180; end
            if ($urandom_range(0, 3) != 0) begin
                fx = nx - int'($urandom_range(0, 175));
                fy = ny - int'($urandom_range(0, 79));
            end else begin
                fx = int'($urandom_range(0, 319));
                fy = int'($urandom_range(0, 199));
            end
            if (fx < 0) fx = 0;
            if (fy < 0) fy = 0;
            rk = {$urandom(), $urandom()} & {$urandom(), $urandom()};
            set_grid(fx, fy, rk[54:0]);
            tick(l, r, f, go, gm);
            pix(m_cx + int'($urandom_range(0, 14)) - 1, 183 + int'($urandom_range(0, 9)));
            if (m_act != 0) pix(m_sx + int'($urandom_range(0, 2)) - 1, m_sy + int'($urandom_range(0, 5)) - 1);
            pix(int'($urandom_range(0, 319)), int'($urandom_range(0, 199)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
